// File: rtl/tail_light_pwm_dimmer.sv
// PWM driver for the left/right tail-light banks: requested lamps full on, the rest at a running-light duty.
// Optional fading of lamp levels is compiled in with `define TLD_FADE_EN.

module tld_lamp #(
    parameter int PWM_BITS = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic                req,
    input  logic [PWM_BITS-1:0] duty_q,
    input  logic [PWM_BITS-1:0] cnt,
`ifdef TLD_FADE_EN
    input  logic                tick,
`endif
    output logic                out
);
    localparam logic [PWM_BITS:0] FULL = {1'b1, {PWM_BITS{1'b0}}};

    logic [PWM_BITS:0] target;
    logic [PWM_BITS:0] lvl;

    always_comb begin
        target = '0;
        if (req)
            target = FULL;
        else if (en)
            target = {1'b0, duty_q};
    end

`ifdef TLD_FADE_EN
    always_ff @(posedge clk) begin
        if (reset)
            lvl <= '0;
        else if (tick) begin
            if (lvl < target)
                lvl <= lvl + 1'b1;
            else if (lvl > target)
                lvl <= lvl - 1'b1;
        end
    end
`else
    // Without fading the level follows the target directly, keeping input-to-pin latency at two edges.
    always_comb lvl = target;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            out <= 1'b0;
        else
            out <= (lvl == FULL) | ({1'b0, cnt} < lvl);
    end
endmodule

module tail_light_pwm_dimmer #(
    parameter int LAMPS    = 3,
    parameter int PWM_BITS = 4,
    parameter int FADE_DIV = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en,
    input  logic [PWM_BITS-1:0] dim_duty,
    input  logic [LAMPS-1:0]    Lcba,
    input  logic [LAMPS-1:0]    Rabc,
    output logic [LAMPS-1:0]    L_out,
    output logic [LAMPS-1:0]    R_out,
    output logic                pwm_wrap
);
    localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

    if (FADE_DIV < 1) begin : g_bad_fade_div
        $error("FADE_DIV must be at least 1");
    end

    logic [PWM_BITS-1:0]  cnt;
    logic [PWM_BITS-1:0]  duty_q;
    logic [2*LAMPS-1:0]   req_q;
    logic [2*LAMPS-1:0]   lamp_out;

    // Duty only moves on the wrap cycle so a period is never cut short or stretched.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= '0;
            duty_q   <= '0;
            req_q    <= '0;
            pwm_wrap <= 1'b0;
        end else begin
            cnt      <= cnt + 1'b1;
            req_q    <= {Lcba, Rabc};
            pwm_wrap <= (cnt == CNT_MAX);
            if (cnt == CNT_MAX)
                duty_q <= dim_duty;
        end
    end

`ifdef TLD_FADE_EN
    localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(FADE_DIV - 1);

    logic [PW-1:0] presc;
    logic          tick;

    assign tick = (presc == PRE_MAX);

    always_ff @(posedge clk) begin
        if (reset || tick)
            presc <= '0;
        else
            presc <= presc + 1'b1;
    end
`endif

    for (genvar i = 0; i < 2*LAMPS; i++) begin : g_lamp
        tld_lamp #(.PWM_BITS(PWM_BITS)) u_lamp (
            .clk    (clk),
            .reset  (reset),
            .en     (en),
            .req    (req_q[i]),
            .duty_q (duty_q),
            .cnt    (cnt),
`ifdef TLD_FADE_EN
            .tick   (tick),
`endif
            .out    (lamp_out[i])
        );
    end

    assign {L_out, R_out} = lamp_out;
endmodule

// File: tb/tb_tail_light_pwm_dimmer.sv
// Randomised bench for tail_light_pwm_dimmer; expected outputs are derived from the recorded input history.
// Under TLD_FADE_EN only the fade scenario runs.

module tb_tail_light_pwm_dimmer;
    localparam int LAMPS = 3;
    localparam int B     = 4;
    localparam int PER   = 16;
    localparam int HMAX  = 8192;
`ifdef TLD_FADE_EN
    localparam int FDIV = 2;
`else
    localparam int FDIV = 16;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic [B-1:0]     dim_duty = '0;
    logic [LAMPS-1:0] Lcba = '0;
    logic [LAMPS-1:0] Rabc = '0;
    logic [LAMPS-1:0] L_out;
    logic [LAMPS-1:0] R_out;
    logic             pwm_wrap;

    int checks = 0;
    int failures = 0;

    tail_light_pwm_dimmer #(.LAMPS(LAMPS), .PWM_BITS(B), .FADE_DIV(FDIV)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .dim_duty (dim_duty),
        .Lcba     (Lcba),
        .Rabc     (Rabc),
        .L_out    (L_out),
        .R_out    (R_out),
        .pwm_wrap (pwm_wrap)
    );

    always #5 clk = ~clk;

    // Input history, one entry per rising edge.
    logic         h_rst  [HMAX];
    logic         h_en   [HMAX];
    logic [B-1:0] h_duty [HMAX];
    logic [5:0]   h_req  [HMAX];
    int           ne = 0;

    always @(posedge clk) begin
        if (ne < HMAX) begin
            h_rst[ne]  <= reset;
            h_en[ne]   <= en;
            h_duty[ne] <= dim_duty;
            h_req[ne]  <= {Lcba, Rabc};
        end
        ne <= ne + 1;
    end

    function automatic int last_reset(input int k);
        int r;
        r = k - 1;
        while (r >= 0 && !h_rst[r]) r--;
        return r;
    endfunction

    // Counter value the design holds just before edge k.
    function automatic int phase_before(input int k);
        return (k - 1 - last_reset(k)) % PER;
    endfunction

    // Expected {pwm_wrap, L_out, R_out} right after edge k.
    function automatic logic [6:0] model(input int k);
        int r, p, duty, lvl;
        logic [5:0] req, o;
        if (h_rst[k]) return '0;
        r = last_reset(k);
        p = (k - 1 - r) % PER;
        duty = 0;
        for (int j = k - 1; j > r; j--) begin
            if ((j - 1 - r) % PER == PER - 1) begin
                duty = int'(h_duty[j]);
                break;
            end
        end
        req = (k - 1 > r) ? h_req[k-1] : 6'b0;
        for (int i = 0; i < 6; i++) begin
            lvl = req[i] ? PER : (h_en[k] ? duty : 0);
            o[i] = (lvl == PER) || (p < lvl);
        end
        return {p == PER - 1, o};
    endfunction

`ifndef TLD_FADE_EN
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if ({pwm_wrap, L_out, R_out} !== 7'b0) begin
                failures++;
                $display("FAIL reset_hold got=%b want=0000000", {pwm_wrap, L_out, R_out});
            end
        end
        reset = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            checks++;
            if (pwm_wrap !== ((c % PER) == 0)) begin
                failures++;
                $display("FAIL reset_wrap clk=%0d got=%b want=%b", c, pwm_wrap, (c % PER) == 0);
            end
            checks++;
            if ({L_out, R_out} !== 6'b0) begin
                failures++;
                $display("FAIL reset_outs clk=%0d got=%b want=000000", c, {L_out, R_out});
            end
        end
    endtask

    task automatic test_dim();
        en = 1'b1; dim_duty = 4'd4; Lcba = '0; Rabc = '0;
        repeat (5 * PER) begin
            @(negedge clk);
            checks++;
            if ({pwm_wrap, L_out, R_out} !== model(ne - 1)) begin
                failures++;
                $display("FAIL dim edge=%0d got=%b want=%b", ne - 1, {pwm_wrap, L_out, R_out}, model(ne - 1));
            end
        end
    endtask

    task automatic test_request();
        Lcba = 3'b101;
        repeat (3 * PER) begin
            @(negedge clk);
            checks++;
            if ({pwm_wrap, L_out, R_out} !== model(ne - 1)) begin
                failures++;
                $display("FAIL request edge=%0d got=%b want=%b", ne - 1, {pwm_wrap, L_out, R_out}, model(ne - 1));
            end
        end
        checks++;
        if (L_out[2] !== 1'b1 || L_out[0] !== 1'b1) begin
            failures++;
            $display("FAIL request_full got=%b want=1x1", L_out);
        end
    endtask

    task automatic test_duty_change();
        Lcba = '0;
        // Change at cnt 6 (kept to the next period) and again on the wrap cycle (captured).
        while (phase_before(ne) != 6) @(negedge clk);
        dim_duty = 4'd12;
        repeat (2 * PER) begin
            @(negedge clk);
            if (phase_before(ne) == PER - 1) dim_duty = 4'd9;
            checks++;
            if ({pwm_wrap, L_out, R_out} !== model(ne - 1)) begin
                failures++;
                $display("FAIL duty_change edge=%0d got=%b want=%b", ne - 1, {pwm_wrap, L_out, R_out}, model(ne - 1));
            end
        end
        repeat (2 * PER) begin
            @(negedge clk);
            checks++;
            if ({pwm_wrap, L_out, R_out} !== model(ne - 1)) begin
                failures++;
                $display("FAIL duty_wrap edge=%0d got=%b want=%b", ne - 1, {pwm_wrap, L_out, R_out}, model(ne - 1));
            end
        end
    endtask

    task automatic test_en_bounds();
        en = 1'b0; dim_duty = 4'd8; Rabc = '0;
        repeat (3 * PER) begin
            @(negedge clk);
            checks++;
            if ({pwm_wrap, L_out, R_out} !== model(ne - 1)) begin
                failures++;
                $display("FAIL en_off edge=%0d got=%b want=%b", ne - 1, {pwm_wrap, L_out, R_out}, model(ne - 1));
            end
        end
        en = 1'b1; dim_duty = 4'd0;
        repeat (3 * PER) @(negedge clk);
        dim_duty = 4'd15;
        Rabc = 3'b111;
        repeat (3 * PER) begin
            @(negedge clk);
            if (phase_before(ne) == 3) en = ~en;
            checks++;
            if ({pwm_wrap, L_out, R_out} !== model(ne - 1)) begin
                failures++;
                $display("FAIL en_bounds edge=%0d got=%b want=%b", ne - 1, {pwm_wrap, L_out, R_out}, model(ne - 1));
            end
        end
        checks++;
        if (R_out !== 3'b111) begin
            failures++;
            $display("FAIL right_full got=%b want=111", R_out);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 700; c++) begin
            if ($urandom_range(7) == 0) en = ~en;
            if ($urandom_range(9) == 0) dim_duty = B'($urandom_range(15));
            if ($urandom_range(3) == 0) {Lcba, Rabc} = 6'($urandom);
            reset = ($urandom_range(99) == 0);
            @(negedge clk);
            checks++;
            if ({pwm_wrap, L_out, R_out} !== model(ne - 1)) begin
                failures++;
                $display("FAIL random edge=%0d got=%b want=%b", ne - 1, {pwm_wrap, L_out, R_out}, model(ne - 1));
            end
        end
        reset = 1'b0;
    endtask
`else
    task automatic test_fade();
        reset = 1'b1; en = 1'b0; Lcba = '0; Rabc = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        Lcba = 3'b001;
        repeat (3) @(negedge clk);
        checks++;
        if (L_out[0] !== 1'b0) begin
            failures++;
            $display("FAIL fade_early got=%b want=0", L_out[0]);
        end
        repeat (40) @(negedge clk);
        repeat (2 * PER) begin
            @(negedge clk);
            checks++;
            if ({L_out, R_out} !== 6'b001000) begin
                failures++;
                $display("FAIL fade_full got=%b want=001000", {L_out, R_out});
            end
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({pwm_wrap, L_out, R_out} !== 7'b0) begin
            failures++;
            $display("FAIL fade_reset got=%b want=0000000", {pwm_wrap, L_out, R_out});
        end
        reset = 1'b0;
        Lcba = '0;
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (L_out !== 3'b000) begin
                failures++;
                $display("FAIL fade_after_reset got=%b want=000", L_out);
            end
        end
    endtask
`endif

    initial begin
`ifndef TLD_FADE_EN
        test_reset();
        test_dim();
        test_request();
        test_duty_change();
        test_en_bounds();
        test_random();
`else
        test_fade();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
